tlb_op_sequencer: RTL

//  Sequences CP0 TLB maintenance instructions (TLBP, TLBR, TLBWI, TLBWR) onto the shared TLB array port.

---
 rtl/tlb_op_sequencer_pkg.sv | 63 ++++++
 rtl/tlb_op_sequencer_random_ctr.sv | 40 ++++
 rtl/tlb_op_sequencer.sv | 148 ++++++++++++++
 3 files changed

// File: rtl/tlb_op_sequencer_pkg.sv
// Shared TLB types for the CP0 TLB-op sequencer: op codes, index/entry
// layouts and small helpers used by the sequencer and its Random counter.
package tlb_op_sequencer_pkg;

  localparam int TLB_NUM        = 32;
  localparam int TLB_INDEX_BITS = $clog2(TLB_NUM);

  typedef enum logic [1:0] {
    TLBP  = 2'd0,
    TLBR  = 2'd1,
    TLBWI = 2'd2,
    TLBWR = 2'd3
  } tlb_op_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_DONE = 2'd2
  } seq_state_t;

  // p=1 marks a probe miss, matching the CP0 Index.P bit.
  typedef struct packed {
    logic                      p;
    logic [TLB_INDEX_BITS-1:0] idx;
  } tlb_index_t;

  typedef struct packed {
    logic [18:0] vpn2;
    logic [7:0]  asid;
  } tlb_entryhi_t;

  typedef struct packed {
    logic [18:0] vpn2;
    logic [7:0]  asid;
    logic [11:0] pagemask;
    logic        g;
    logic [19:0] pfn0;
    logic [2:0]  c0;
    logic        d0;
    logic        v0;
    logic [19:0] pfn1;
    logic [2:0]  c1;
    logic        d1;
    logic        v1;
  } tlb_entry_t;

  function automatic logic is_write_op(input tlb_op_t op);
    return (op == TLBWI) || (op == TLBWR);
  endfunction

  // A miss leaves the index field undefined in the array, so it is forced to zero.
  function automatic tlb_index_t probe_result(input tlb_index_t raw);
    tlb_index_t r;
    if (raw.p) begin
      r.p   = 1'b1;
      r.idx = '0;
    end else begin
      r = raw;
    end
    return r;
  endfunction

endpackage

// File: rtl/tlb_op_sequencer_random_ctr.sv
// CP0 Random register: free-running down-counter from TLB_NUM-1 to Wired,
// reloaded by any write to Wired.
module tlb_random_ctr #(
  parameter int TLB_NUM = 32
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [$clog2(TLB_NUM)-1:0] wired,
  input  logic                       wired_we,
  output logic [$clog2(TLB_NUM)-1:0] random
);

  localparam int W = $clog2(TLB_NUM);
  localparam logic [W-1:0] RANDOM_MAX = W'(TLB_NUM - 1);

  logic [W-1:0] random_next;

  // Wired write wins; a Wired at or above the top entry pins Random there.
  always_comb begin
    random_next = random;
    if (wired_we) begin
      random_next = RANDOM_MAX;
    end else if (wired >= RANDOM_MAX) begin
      random_next = RANDOM_MAX;
    end else if (random == wired) begin
      random_next = RANDOM_MAX;
    end else begin
      random_next = random - {{(W-1){1'b0}}, 1'b1};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      random <= RANDOM_MAX;
    end else begin
      random <= random_next;
    end
  end

endmodule

// File: rtl/tlb_op_sequencer.sv
// Sequences TLBP/TLBR/TLBWI/TLBWR onto the shared TLB port as a fixed
// IDLE -> EXEC -> DONE handshake and returns probe/read results to CP0.
module tlb_op_sequencer
  import tlb_op_sequencer_pkg::*;
(
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      op_valid,
  input  tlb_op_t                   op_type,
  output logic                      op_ready,
  output logic                      busy,
  output logic                      done,
  input  tlb_index_t                cp0_index,
  input  tlb_entryhi_t              cp0_entryhi,
  input  tlb_entry_t                cp0_entry,
  input  logic [TLB_INDEX_BITS-1:0] cp0_wired,
  input  logic                      wired_we,
  output logic [TLB_INDEX_BITS-1:0] random,
  output tlb_index_t                tlb_index,
  output logic                      tlb_we,
  output tlb_entry_t                tlb_wdata,
  input  tlb_entry_t                tlb_rdata,
  output tlb_entryhi_t              tlbp_entryhi,
  input  tlb_index_t                tlbp_index,
  output logic                      idx_we,
  output tlb_index_t                idx_wdata,
  output logic                      entry_we,
  output tlb_entry_t                entry_wdata
);

  seq_state_t   state;
  seq_state_t   state_next;
  tlb_op_t      op_q;
  tlb_index_t   index_q;
  tlb_entryhi_t entryhi_q;
  tlb_entry_t   entry_q;
  tlb_index_t   res_index;
  tlb_entry_t   res_entry;
  logic         accept;

  tlb_random_ctr #(
    .TLB_NUM (TLB_NUM)
  ) u_random (
    .clk      (clk),
    .rst      (rst),
    .wired    (cp0_wired),
    .wired_we (wired_we),
    .random   (random)
  );

  assign accept = (state == ST_IDLE) && op_valid;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: begin
        if (op_valid) begin
          state_next = ST_EXEC;
        end else begin
          state_next = ST_IDLE;
        end
      end
      ST_EXEC: state_next = ST_DONE;
      ST_DONE: state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  // Strobes are masked by rst so an op cut short by reset never touches the TLB or CP0.
  always_comb begin
    op_ready = 1'b0;
    busy     = 1'b0;
    done     = 1'b0;
    tlb_we   = 1'b0;
    idx_we   = 1'b0;
    entry_we = 1'b0;
    case (state)
      ST_IDLE: op_ready = 1'b1;
      ST_EXEC: begin
        busy   = 1'b1;
        tlb_we = is_write_op(op_q) && !rst;
      end
      ST_DONE: begin
        busy     = 1'b1;
        done     = !rst;
        idx_we   = (op_q == TLBP) && !rst;
        entry_we = (op_q == TLBR) && !rst;
      end
      default: begin
        op_ready = 1'b0;
      end
    endcase
  end

  // TLBWR captures Random as it stands in the accept cycle, before any Wired reload.
  always_ff @(posedge clk) begin
    if (rst) begin
      op_q      <= TLBP;
      index_q   <= '0;
      entryhi_q <= '0;
      entry_q   <= '0;
    end else if (accept) begin
      op_q      <= op_type;
      entryhi_q <= cp0_entryhi;
      entry_q   <= cp0_entry;
      if (op_type == TLBWR) begin
        index_q.p   <= 1'b0;
        index_q.idx <= random;
      end else begin
        index_q <= cp0_index;
      end
    end else begin
      op_q <= op_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      res_index <= '0;
      res_entry <= '0;
    end else if (state == ST_EXEC) begin
      if (op_q == TLBP) begin
        res_index <= probe_result(tlbp_index);
      end else if (op_q == TLBR) begin
        res_entry <= tlb_rdata;
      end else begin
        res_index <= res_index;
      end
    end else begin
      res_index <= res_index;
    end
  end

  assign tlb_index    = index_q;
  assign tlb_wdata    = entry_q;
  assign tlbp_entryhi = entryhi_q;
  assign idx_wdata    = res_index;
  assign entry_wdata  = res_entry;

endmodule
